regfile_sp_param: RTL and testbench

Parametrised general-purpose register file for the pipelined core: two asynchronous read ports, one synchronous write port and one dedicated stack-pointer register. The stack pointer has hardware push/pop stepping with saturating bounds and sticky overflow/underflow flags. Optional write-to-read bypass lets the decode stage see same-cycle writeback without a separate forwarding path. It sits between the decode stage (reads) and the writeback stage (writes, SP updates).

---
 rtl/regfile_sp_param.sv | 101 ++++++++++
 tb/tb_regfile_sp_param.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sp_param.sv
// Register file with two combinational read ports, one write port and a stack-pointer
// register that has saturating push/pop stepping and sticky overflow/underflow flags.
module regfile_sp_param #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       NUM_REGS = 4,
    parameter int unsigned       SP_IDX   = NUM_REGS - 1,
    parameter logic [DATA_W-1:0] SP_RESET = '1,
    parameter logic [DATA_W-1:0] SP_MIN   = '0,
    parameter bit                BYPASS   = 1'b1,
    localparam int unsigned      ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              sp_en,
    input  logic              sp_op,
    input  logic              flag_clr,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic [DATA_W-1:0] sp_out,
    output logic              sp_ovf,
    output logic              sp_unf
);

    if (NUM_REGS < 2) begin : g_chk_num_regs
        $error("regfile_sp_param: NUM_REGS must be at least 2");
    end
    if (SP_IDX >= NUM_REGS) begin : g_chk_sp_idx
        $error("regfile_sp_param: SP_IDX must be below NUM_REGS");
    end
    if (SP_MIN >= SP_RESET) begin : g_chk_sp_bounds
        $error("regfile_sp_param: SP_MIN must be below SP_RESET");
    end

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              sp_ovf_q, sp_ovf_d;
    logic              sp_unf_q, sp_unf_d;
    logic [DATA_W-1:0] sp_cur;
    logic [DATA_W-1:0] sp_step;
    logic              ovf_set;
    logic              unf_set;

    always_comb begin
        sp_cur  = regs_q[SP_IDX];
        sp_step = sp_cur;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (sp_en) begin
            if (sp_op) begin
                if (sp_cur == SP_RESET) unf_set = 1'b1;
                else                    sp_step = sp_cur + DATA_W'(1);
            end else begin
                if (sp_cur == SP_MIN)   ovf_set = 1'b1;
                else                    sp_step = sp_cur - DATA_W'(1);
            end
        end

        // Out-of-range write indices match no entry and are dropped here.
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (we && (waddr == i[ADDR_W-1:0])) regs_d[i] = wdata;
        end
        // A step overrides a same-cycle write to the SP entry.
        if (sp_en) regs_d[SP_IDX] = sp_step;

        sp_ovf_d = ovf_set | (sp_ovf_q & ~flag_clr);
        sp_unf_d = unf_set | (sp_unf_q & ~flag_clr);
    end

    always_comb begin
        ra_data = '0;
        rb_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (ra == i[ADDR_W-1:0]) ra_data = BYPASS ? regs_d[i] : regs_q[i];
            if (rb == i[ADDR_W-1:0]) rb_data = BYPASS ? regs_d[i] : regs_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            regs_q[SP_IDX] <= SP_RESET;
            sp_ovf_q       <= 1'b0;
            sp_unf_q       <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            sp_ovf_q <= sp_ovf_d;
            sp_unf_q <= sp_unf_d;
        end
    end

    assign sp_out = regs_q[SP_IDX];
    assign sp_ovf = sp_ovf_q;
    assign sp_unf = sp_unf_q;

endmodule

// File: tb/tb_regfile_sp_param.sv
// Scoreboard bench for regfile_sp_param: default bypassed build, a BYPASS=0 build sharing
// its inputs, and a 6-entry 16-bit build.
module tb_regfile_sp_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       we, sp_en, sp_op, flag_clr;
    logic [1:0] waddr, ra, rb;
    logic [7:0] wdata;
    logic [7:0] a_ra, a_rb, a_sp, b_ra, b_rb, b_sp;
    logic       a_ovf, a_unf, b_ovf, b_unf;

    logic        we2, sp_en2, sp_op2, flag_clr2;
    logic [2:0]  waddr2, ra2, rb2;
    logic [15:0] wdata2, c_ra, c_rb, c_sp;
    logic        c_ovf, c_unf;

    regfile_sp_param #(.BYPASS(1'b1)) u_a (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .sp_en(sp_en), .sp_op(sp_op), .flag_clr(flag_clr), .ra(ra), .rb(rb),
        .ra_data(a_ra), .rb_data(a_rb), .sp_out(a_sp), .sp_ovf(a_ovf), .sp_unf(a_unf)
    );

    regfile_sp_param #(.BYPASS(1'b0)) u_b (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .sp_en(sp_en), .sp_op(sp_op), .flag_clr(flag_clr), .ra(ra), .rb(rb),
        .ra_data(b_ra), .rb_data(b_rb), .sp_out(b_sp), .sp_ovf(b_ovf), .sp_unf(b_unf)
    );

    regfile_sp_param #(.DATA_W(16), .NUM_REGS(6), .SP_IDX(5), .SP_RESET(16'h0FFF)) u_c (
        .clk(clk), .rst(rst), .we(we2), .waddr(waddr2), .wdata(wdata2),
        .sp_en(sp_en2), .sp_op(sp_op2), .flag_clr(flag_clr2), .ra(ra2), .rb(rb2),
        .ra_data(c_ra), .rb_data(c_rb), .sp_out(c_sp), .sp_ovf(c_ovf), .sp_unf(c_unf)
    );

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic expect_val(input string tag, input logic [15:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [15:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL sb_underflow: got %h, expected nothing queued", obs);
        end else begin
            e = sb.pop_front();
            check(e.tag, obs, e.exp);
        end
    endtask

    // Reference model of the default 4 x 8-bit build (SP at index 3, bounds 0x00..0xFF).
    logic [7:0] m_reg [4];
    logic       m_ovf, m_unf;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_reg[3] = 8'hFF;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
    endtask

    function automatic logic [7:0] m_next(input logic [1:0] idx);
        logic [7:0] v;
        v = m_reg[idx];
        if (idx == 2'd3 && sp_en) begin
            if (sp_op) v = (m_reg[3] == 8'hFF) ? 8'hFF : m_reg[3] + 8'd1;
            else       v = (m_reg[3] == 8'h00) ? 8'h00 : m_reg[3] - 8'd1;
        end else if (we && waddr == idx) begin
            v = wdata;
        end
        return v;
    endfunction

    task automatic model_edge();
        logic [7:0] n [4];
        logic       ovf_hit, unf_hit;
        for (int i = 0; i < 4; i++) n[i] = m_next(2'(i));
        unf_hit = sp_en &&  sp_op && (m_reg[3] == 8'hFF);
        ovf_hit = sp_en && !sp_op && (m_reg[3] == 8'h00);
        m_unf   = unf_hit | (m_unf & ~flag_clr);
        m_ovf   = ovf_hit | (m_ovf & ~flag_clr);
        m_reg   = n;
    endtask

    task automatic drv(input logic w, input logic [1:0] wa, input logic [7:0] wd,
                       input logic se, input logic so, input logic fc,
                       input logic [1:0] a, input logic [1:0] b);
        we = w; waddr = wa; wdata = wd; sp_en = se; sp_op = so; flag_clr = fc; ra = a; rb = b;
    endtask

    // One clock of the shared-input pair: reads checked before the edge, state after it.
    task automatic cyc(input logic w, input logic [1:0] wa, input logic [7:0] wd,
                       input logic se, input logic so, input logic fc,
                       input logic [1:0] a, input logic [1:0] b);
        drv(w, wa, wd, se, so, fc, a, b);
        expect_val("a_ra_bypass", 16'(m_next(a)));
        expect_val("a_rb_bypass", 16'(m_next(b)));
        expect_val("b_ra_stored", 16'(m_reg[a]));
        expect_val("b_rb_stored", 16'(m_reg[b]));
        #2;
        pop_check(16'(a_ra)); pop_check(16'(a_rb));
        pop_check(16'(b_ra)); pop_check(16'(b_rb));
        model_edge();
        expect_val("a_sp", 16'(m_reg[3])); expect_val("a_ovf", 16'(m_ovf)); expect_val("a_unf", 16'(m_unf));
        expect_val("b_sp", 16'(m_reg[3])); expect_val("b_ovf", 16'(m_ovf)); expect_val("b_unf", 16'(m_unf));
        @(posedge clk); #1;
        pop_check(16'(a_sp)); pop_check(16'(a_ovf)); pop_check(16'(a_unf));
        pop_check(16'(b_sp)); pop_check(16'(b_ovf)); pop_check(16'(b_unf));
    endtask

    task automatic const_chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        expect_val(tag, exp);
        pop_check(obs);
    endtask

    logic [7:0] sp_vals [5] = '{8'h00, 8'h01, 8'hFE, 8'hFF, 8'h80};

    initial begin
        rst = 1'b0;
        drv(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3);
        we2 = 1'b0; waddr2 = 3'd0; wdata2 = 16'h0; sp_en2 = 1'b0; sp_op2 = 1'b0;
        flag_clr2 = 1'b0; ra2 = 3'd5; rb2 = 3'd0;
        model_reset();
        #12;
        const_chk("rst_r0", 16'(a_ra), 16'h0000);
        const_chk("rst_sp_read", 16'(a_rb), 16'h00FF);
        const_chk("rst_sp_out", 16'(a_sp), 16'h00FF);
        const_chk("rst_ovf", 16'(a_ovf), 16'h0000);
        const_chk("rst_unf", 16'(a_unf), 16'h0000);
        const_chk("c_rst_reg5", c_ra, 16'h0FFF);
        const_chk("c_rst_sp_out", c_sp, 16'h0FFF);
        const_chk("c_rst_reg0", c_rb, 16'h0000);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        cyc(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2);

        // Reset landing on a pending write must leave the register at zero.
        cyc(1'b1, 2'd0, 8'h33, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        drv(1'b1, 2'd0, 8'h5A, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        #2; rst = 1'b0;
        @(posedge clk); #1;
        drv(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        rst = 1'b1;
        model_reset();
        #1;
        const_chk("rst_midwrite_r0", 16'(a_ra), 16'h0000);
        @(posedge clk); #1;

        drv(1'b1, 2'd1, 8'hA5, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1);
        #2;
        const_chk("bypass_pre_edge", 16'(a_ra), 16'h00A5);
        const_chk("nobypass_pre_edge", 16'(b_ra), 16'h0000);
        model_edge();
        @(posedge clk); #1;
        cyc(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0);
        const_chk("bypass_after", 16'(a_ra), 16'h00A5);
        const_chk("nobypass_after", 16'(b_ra), 16'h00A5);

        for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0);
        const_chk("push3_sp", 16'(a_sp), 16'h00FC);
        for (int i = 0; i < 2; i++) cyc(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd3, 2'd0);
        const_chk("pop2_sp", 16'(a_sp), 16'h00FE);
        const_chk("pop2_flags", 16'({a_ovf, a_unf}), 16'h0000);

        cyc(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd3, 2'd0);
        cyc(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd3, 2'd0);
        const_chk("unf_sp_hold", 16'(a_sp), 16'h00FF);
        const_chk("unf_set", 16'(a_unf), 16'h0001);
        cyc(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0);
        const_chk("unf_sticky", 16'(a_unf), 16'h0001);
        cyc(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd3, 2'd0);
        const_chk("unf_set_wins_clr", 16'(a_unf), 16'h0001);
        cyc(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0);
        const_chk("unf_cleared", 16'(a_unf), 16'h0000);

        cyc(1'b1, 2'd3, 8'h00, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0);
        cyc(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0);
        const_chk("ovf_sp_hold", 16'(a_sp), 16'h0000);
        const_chk("ovf_set", 16'(a_ovf), 16'h0001);

        // Reset over a pending step and write, with a flag already set.
        drv(1'b1, 2'd1, 8'h77, 1'b1, 1'b1, 1'b0, 2'd1, 2'd3);
        #2; rst = 1'b0;
        @(posedge clk); #1;
        drv(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 2'd3);
        rst = 1'b1;
        model_reset();
        #1;
        const_chk("rst_mid_r1", 16'(a_ra), 16'h0000);
        const_chk("rst_mid_sp", 16'(a_sp), 16'h00FF);
        const_chk("rst_mid_ovf", 16'(a_ovf), 16'h0000);
        @(posedge clk); #1;

        cyc(1'b1, 2'd3, 8'h80, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0);
        cyc(1'b1, 2'd3, 8'h40, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0);
        const_chk("collision_sp", 16'(a_sp), 16'h007F);

        for (int k = 0; k < 300; k++) begin
            logic [1:0] wa;
            logic [7:0] wd;
            wa = 2'($urandom_range(0, 3));
            wd = (wa == 2'd3) ? sp_vals[$urandom_range(0, 4)] : 8'($urandom);
            cyc(1'($urandom_range(0, 1)), wa, wd, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end
        drv(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

        we2 = 1'b1; waddr2 = 3'd7; wdata2 = 16'h1234; ra2 = 3'd7; rb2 = 3'd4;
        #2;
        const_chk("c_read_idx7_pre", c_ra, 16'h0000);
        const_chk("c_r4_pre", c_rb, 16'h0000);
        @(posedge clk); #1;
        we2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ra2 = 3'(i);
            #1;
            const_chk("c_no_alias_write", c_ra, 16'h0000);
        end
        ra2 = 3'd7;
        #1;
        const_chk("c_read_idx7", c_ra, 16'h0000);
        const_chk("c_sp_untouched", c_sp, 16'h0FFF);
        @(posedge clk); #1;
        we2 = 1'b1; waddr2 = 3'd4; wdata2 = 16'hBEEF; ra2 = 3'd4;
        #2;
        const_chk("c_r4_bypass", c_ra, 16'hBEEF);
        @(posedge clk); #1;
        we2 = 1'b0; sp_en2 = 1'b1; sp_op2 = 1'b0;
        @(posedge clk); #1;
        const_chk("c_push_sp", c_sp, 16'h0FFE);
        sp_op2 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sp_en2 = 1'b0;
        const_chk("c_pop_sat_sp", c_sp, 16'h0FFF);
        const_chk("c_unf", 16'(c_unf), 16'h0001);
        const_chk("c_r4_held", c_ra, 16'hBEEF);

        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL sb_leftover: got %0d entries, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
